// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_pkg
//  Description : Shared sizes and FSM state encoding for the 8-way
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    // Number of requesters; tied to the width of the 8-to-3 encoder.
    localparam int N     = 8;
    // Width of the encoded grant index.
    localparam int IDX_W = 3;

    // Arbiter states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/prio_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pick8
//  Description : Combinational 8-to-3 priority encoder. Returns the index of
//                the highest set bit and a valid flag when any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_pick8
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : prio_pick8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Eight-requester round-robin arbiter with registered one-hot
//                and encoded grant, rotating priority and an optional limit
//                on consecutive grant cycles per tenure.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,   // 0 = unlimited tenure
    parameter int CNT_W    = 4    // must be wide enough to hold MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [N-1:0]     C_ONE_N    = N'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    logic             w_cur_drop;
    logic             w_timeout;
    logic             w_tenure_end;
    logic [N-1:0]     w_req_eff;
    logic [N-1:0]     w_mask;
    logic [IDX_W-1:0] w_masked_idx;
    logic             w_masked_valid;
    logic [IDX_W-1:0] w_raw_idx;
    logic             w_raw_valid;
    logic [IDX_W-1:0] w_pick;

    // The current holder is excluded from the next pick only if it released
    // its request; on a timeout it stays eligible so a lone requester is
    // re-granted without a gap.
    assign w_cur_drop   = (r_state == GRANT) && !req[r_gnt_idx];
    assign w_req_eff    = req & ~(w_cur_drop ? (C_ONE_N << r_gnt_idx) : '0);
    assign w_timeout    = (MAX_HOLD != 0) && (r_hold_cnt == C_HOLD_MAX);
    assign w_tenure_end = w_cur_drop || w_timeout;

    // Only requesters strictly below the last winner get first chance.
    assign w_mask = w_req_eff & ((C_ONE_N << r_last) - C_ONE_N);

    prio_pick8 u_pick_masked (
        .req   (w_mask),
        .idx   (w_masked_idx),
        .valid (w_masked_valid)
    );

    prio_pick8 u_pick_raw (
        .req   (w_req_eff),
        .idx   (w_raw_idx),
        .valid (w_raw_valid)
    );

    assign w_pick = w_masked_valid ? w_masked_idx : w_raw_idx;

    // State, grant and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last     <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Next-state and next-grant decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_last_nxt     = r_last;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            IDLE: begin
                if (en && w_raw_valid) begin
                    w_state_nxt    = GRANT;
                    w_gnt_nxt      = C_ONE_N << w_pick;
                    w_gnt_idx_nxt  = w_pick;
                    w_last_nxt     = w_pick;
                    w_hold_cnt_nxt = C_CNT_ONE;
                end else begin
                    w_gnt_nxt     = '0;
                    w_gnt_idx_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_tenure_end) begin
                    if (r_hold_cnt != '1) begin
                        w_hold_cnt_nxt = r_hold_cnt + C_CNT_ONE;
                    end
                end else if (en && w_raw_valid) begin
                    w_gnt_nxt      = C_ONE_N << w_pick;
                    w_gnt_idx_nxt  = w_pick;
                    w_last_nxt     = w_pick;
                    w_hold_cnt_nxt = C_CNT_ONE;
                end else begin
                    w_state_nxt    = IDLE;
                    w_gnt_nxt      = '0;
                    w_gnt_idx_nxt  = '0;
                    w_hold_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_gnt_nxt      = '0;
                w_gnt_idx_nxt  = '0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = |r_gnt;

    // The grant vector is never allowed to name two requesters at once.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule : rr_arbiter8
`default_nettype wire
